instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: streams sequential word addresses to a synchronous
// instruction memory and presents one registered instruction per cycle to
// decode. A one-entry skid buffer absorbs the in-flight read when decode
// stalls, so no fetched word is lost or duplicated. A redirect restarts
// fetch at a new target and flushes everything in flight.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] AddressBus,
  input  logic [15:0] InstructionReg,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        instr_valid
);

  // FILL: first read issued, nothing returned yet.
  // RUN:  memory data is flowing straight into the output register.
  // HOLD: output is stalled and the in-flight word sits in the skid buffer.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] inflight_pc_q, inflight_pc_d;
  logic [15:0] skid_q, skid_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;

  // The address bus is the pc register itself: no input reaches it combinationally.
  assign AddressBus  = pc_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

  // Next-state logic; redirect overrides every state and any stall.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    skid_d        = skid_q;
    skid_pc_d     = skid_pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    valid_d       = valid_q;

    if (redirect_valid) begin
      // Whatever is on the output is either consumed this edge or abandoned;
      // the skid and in-flight reads are simply never used again.
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = FILL;
    end else begin
      case (state_q)
        FILL: begin
          inflight_pc_d = pc_q;
          pc_d          = pc_q + 16'd1;
          state_d       = RUN;
        end
        RUN: begin
          if (!valid_q || !stall) begin
            instr_d       = InstructionReg;
            pc_out_d      = inflight_pc_q;
            valid_d       = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + 16'd1;
          end else begin
            // Memory data for inflight_pc is only valid this cycle; park it.
            // pc is held, so memory keeps re-reading the next address.
            skid_d    = InstructionReg;
            skid_pc_d = inflight_pc_q;
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d       = skid_q;
            pc_out_d      = skid_pc_q;
            valid_d       = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + 16'd1;
            state_d       = RUN;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  // State register; reset wins over redirect and stall from any state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FILL;
      pc_q          <= RESET_PC;
      inflight_pc_q <= 16'h0000;
      skid_q        <= 16'h0000;
      skid_pc_q     <= 16'h0000;
      instr_q       <= 16'h0000;
      pc_out_q      <= 16'h0000;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      skid_q        <= skid_d;
      skid_pc_q     <= skid_pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      valid_q       <= valid_d;
    end
  end

endmodule
